// File: rtl/ibert_capture_pkg.sv
// ibert_capture_pkg
// Shared definitions for the IBERT sample-capture memory. The clkA capture
// writer and the clkB readout logic both import this package so that the
// state encoding and the address width derivation stay in one place.
//
// Contents:
//   cap_state_t      - capture controller state enum
//   ST_*             - the same encodings as plain constants for older code
//   cap_addr_width() - memory address width for a given DEPTH
package ibert_capture_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ARMED = 2'd1,
        CAP_POST  = 2'd2,
        CAP_DONE  = 2'd3
    } cap_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Address width needed to index a DEPTH-entry memory.
    function automatic int cap_addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_decim.sv
// capture_decim
// Sample decimator for the capture writer. While the writer is collecting
// samples, only every (decim+1)-th valid sample is accepted. A trigger that
// arrives on a skipped sample is remembered and attached to the next
// accepted sample so a trigger is never lost to decimation.
//
// Ports:
//   clkA       - capture clock
//   rst        - synchronous active-high reset
//   load_i     - capture start; loads decim_i and restarts the count
//   decim_i    - decimation factor minus one
//   active_i   - writer is in a state that stores samples
//   s_valid_i  - input sample qualifier
//   trigger_i  - input trigger (only meaningful with s_valid_i)
//   accept_o   - this valid sample is to be written
//   trigger_o  - the accepted sample carries a (possibly deferred) trigger
module capture_decim (
    input  logic       clkA,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] decim_i,
    input  logic       active_i,
    input  logic       s_valid_i,
    input  logic       trigger_i,
    output logic       accept_o,
    output logic       trigger_o
);

    logic [7:0] decim_q;
    logic [7:0] cnt_q;
    logic       pending_q;
    logic       hit;

    assign hit       = active_i && s_valid_i;
    assign accept_o  = hit && (cnt_q == 8'd0);
    assign trigger_o = accept_o && (trigger_i || pending_q);

    // The counter walks 0..decim over valid samples; a sample is taken when it
    // reads zero, so the first valid sample after arming is always kept.
    always_ff @(posedge clkA) begin
        if (rst) begin
            decim_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else if (load_i) begin
            decim_q   <= decim_i;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else if (hit) begin
            cnt_q <= (cnt_q == decim_q) ? 8'd0 : cnt_q + 8'd1;
            if (accept_o) begin
                pending_q <= 1'b0;
            end else if (trigger_i) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/capture_writer.sv
// capture_writer
// Write-side controller for the IBERT sample-capture memory. Samples arriving
// on clkA are written into the memory write port as a circular buffer. After
// a trigger, a programmed number of further samples is written and capture
// freezes so the clkB readout can unroll the buffer from start_addr.
//
// Optional feature: define CAPTURE_DECIM_EN to add the decim input and keep
// only every (decim+1)-th valid sample while capturing.
//
// Ports:
//   clkA        - capture clock
//   rst         - synchronous active-high reset
//   decim       - (CAPTURE_DECIM_EN only) decimation factor minus one, taken on arm
//   arm         - one-cycle pulse that starts a capture from IDLE or DONE
//   post_count  - samples to write after the trigger sample, taken on arm
//   s_data      - sample data
//   s_valid     - sample qualifier, no backpressure
//   trigger     - trigger flag, qualified by s_valid
//   weA/enA     - memory write enable / port enable (identical)
//   addrA/dinA  - memory write address / data
//   busy        - capture in progress (ARMED or POST)
//   done        - capture complete (DONE)
//   wrapped     - write pointer has wrapped at least once this capture
//   trig_addr   - address of the trigger sample
//   start_addr  - oldest valid address in the buffer
module capture_writer
    import ibert_capture_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 512,
    localparam int AW    = cap_addr_width(DEPTH)
) (
    input  logic             clkA,
    input  logic             rst,
`ifdef CAPTURE_DECIM_EN
    input  logic [7:0]       decim,
`endif
    input  logic             arm,
    input  logic [AW-1:0]    post_count,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             trigger,
    output logic             weA,
    output logic             enA,
    output logic [AW-1:0]    addrA,
    output logic [WIDTH-1:0] dinA,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic [AW-1:0]    trig_addr,
    output logic [AW-1:0]    start_addr
);

    logic [1:0]       state_q,    state_d;
    logic [AW-1:0]    wrPtr_q,    wrPtr_d;
    logic [AW-1:0]    postCnt_q,  postCnt_d;
    logic [AW-1:0]    trigAddr_q, trigAddr_d;
    logic             wrapped_q,  wrapped_d;
    logic             we_q,       we_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic [WIDTH-1:0] din_q,      din_d;

    logic active;
    logic startCap;
    logic accept;
    logic accTrig;

    assign active   = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign startCap = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CAPTURE_DECIM_EN
    capture_decim u_decim (
        .clkA      (clkA),
        .rst       (rst),
        .load_i    (startCap),
        .decim_i   (decim),
        .active_i  (active),
        .s_valid_i (s_valid),
        .trigger_i (trigger),
        .accept_o  (accept),
        .trigger_o (accTrig)
    );
`else
    assign accept  = s_valid;
    assign accTrig = s_valid && trigger;
`endif

    // Next-state logic. Any accepted sample in ARMED or POST becomes exactly
    // one registered write next cycle; the state register moves in the same
    // edge, so done appears together with the final write.
    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        postCnt_d  = postCnt_q;
        trigAddr_d = trigAddr_q;
        wrapped_d  = wrapped_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;

        if (active && accept) begin
            we_d    = 1'b1;
            addr_d  = wrPtr_q;
            din_d   = s_data;
            wrPtr_d = wrPtr_q + 1'b1;
            if (wrPtr_q == AW'(DEPTH - 1)) begin
                wrapped_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A sample arriving with arm is dropped; capture begins next cycle.
                if (arm) begin
                    state_d    = ST_ARMED;
                    wrPtr_d    = '0;
                    wrapped_d  = 1'b0;
                    postCnt_d  = post_count;
                    trigAddr_d = '0;
                end
            end
            ST_ARMED: begin
                if (accept && accTrig) begin
                    trigAddr_d = wrPtr_q;
                    state_d    = (postCnt_q == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (accept) begin
                    postCnt_d = postCnt_q - 1'b1;
                    if (postCnt_q == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts a capture without a further write.
    always_ff @(posedge clkA) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wrPtr_q    <= '0;
            postCnt_q  <= '0;
            trigAddr_q <= '0;
            wrapped_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            postCnt_q  <= postCnt_d;
            trigAddr_q <= trigAddr_d;
            wrapped_q  <= wrapped_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign weA        = we_q;
    assign enA        = we_q;
    assign addrA      = addr_q;
    assign dinA       = din_q;
    assign busy       = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done       = (state_q == ST_DONE);
    assign wrapped    = wrapped_q;
    assign trig_addr  = trigAddr_q;
    // Once wrapped, the next slot to be overwritten holds the oldest sample.
    assign start_addr = wrapped_q ? wrPtr_q : '0;

endmodule

// File: tb/tb_capture_writer.sv
// tb_capture_writer
// Self-checking bench for capture_writer with DEPTH=16. Each scenario task
// drives a capture and compares the observed memory writes and status
// outputs with a model derived from the capture rules: the k-th accepted
// sample after arm lands at address k mod DEPTH, and the capture holds the
// trigger sample plus post_count further samples.
module tb_capture_writer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clkA = 1'b0;
    logic             rst = 1'b1;
    logic             arm = 1'b0;
    logic [AW-1:0]    post_count = '0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             trigger = 1'b0;
    logic             weA, enA, busy, done, wrapped;
    logic [AW-1:0]    addrA, trig_addr, start_addr;
    logic [WIDTH-1:0] dinA;

    int checkCount = 0;
    int errCount   = 0;
    int enErr      = 0;

    logic [AW-1:0]    wAddrQ[$];
    logic [WIDTH-1:0] wDataQ[$];
    logic             wDoneQ[$];
    logic             wBusyQ[$];

    capture_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clkA       (clkA),
        .rst        (rst),
`ifdef CAPTURE_DECIM_EN
        .decim      (8'd0),
`endif
        .arm        (arm),
        .post_count (post_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .trigger    (trigger),
        .weA        (weA),
        .enA        (enA),
        .addrA      (addrA),
        .dinA       (dinA),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    always #5 clkA = ~clkA;

    // Write monitor: logs every memory write seen at the falling edge.
    always @(negedge clkA) begin
        if (enA !== weA) enErr++;
        if (weA === 1'b1) begin
            wAddrQ.push_back(addrA);
            wDataQ.push_back(dinA);
            wDoneQ.push_back(done);
            wBusyQ.push_back(busy);
        end
    end

    task automatic tick();
        @(posedge clkA);
        #1;
    endtask

    task automatic clearLog();
        wAddrQ.delete();
        wDataQ.delete();
        wDoneQ.delete();
        wBusyQ.delete();
    endtask

    task automatic checkIdleOutputs(input string name);
        logic [63:0] got;
        got = {weA, enA, busy, done, wrapped, addrA, trig_addr, start_addr, dinA};
        checkCount++;
        if (got !== 64'd0) begin
            errCount++;
            $display("[TB] FAIL %s: outputs got %h expected all zero", name, got);
        end
    endtask

    // Runs one capture. gap: 0 continuous, >0 valid every gap+1 cycles,
    // <0 random valid. armInPost re-pulses arm on the first post sample.
    task automatic run_capture(input int post, input int trigIdx, input int gap,
                               input bit armInPost, input bit fixData, input string name);
        int sent;
        int cyc;
        int n;
        bit v;
        bit expWrap;
        logic [AW-1:0] expStart;
        logic [WIDTH-1:0] sentQ[$];
        n = trigIdx + post + 1;
        clearLog();
        arm = 1'b1;
        post_count = AW'(post);
        s_valid = 1'b1;
        s_data = $urandom;
        trigger = 1'b1;
        tick();
        arm = 1'b0;
        checkCount++;
        if (busy !== 1'b1 || done !== 1'b0 || wrapped !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL %s_armed: busy/done/wrapped got %b%b%b expected 100", name, busy, done, wrapped);
        end
        sent = 0;
        cyc = 0;
        while (sent < n + 3 && cyc < 2000) begin
            if (gap == 0) v = 1'b1;
            else if (gap < 0) v = 1'($urandom % 2);
            else v = (cyc % (gap + 1) == 0);
            s_valid = v;
            s_data = $urandom;
            post_count = AW'($urandom);
            trigger = 1'b0;
            if (v) begin
                if (sent == trigIdx) begin
                    trigger = 1'b1;
                    if (fixData) s_data = 32'h55;
                end else if (sent > trigIdx) begin
                    trigger = 1'($urandom % 2);
                end
                if (armInPost && post >= 1 && sent == trigIdx + 1) arm = 1'b1;
                sentQ.push_back(s_data);
                sent++;
            end else begin
                trigger = 1'($urandom % 2);
            end
            tick();
            arm = 1'b0;
            cyc++;
        end
        s_valid = 1'b0;
        trigger = 1'b0;
        repeat (3) tick();

        checkCount++;
        if (wAddrQ.size() != n) begin
            errCount++;
            $display("[TB] FAIL %s_count: writes got %0d expected %0d", name, wAddrQ.size(), n);
        end
        for (int i = 0; i < n && i < wAddrQ.size() && i < sentQ.size(); i++) begin
            checkCount++;
            if (wAddrQ[i] !== AW'(i % DEPTH) || wDataQ[i] !== sentQ[i]) begin
                errCount++;
                $display("[TB] FAIL %s_write%0d: addr/data got %0h/%0h expected %0h/%0h",
                         name, i, wAddrQ[i], wDataQ[i], i % DEPTH, sentQ[i]);
            end
            checkCount++;
            if (wDoneQ[i] !== (i == n - 1) || wBusyQ[i] !== (i != n - 1)) begin
                errCount++;
                $display("[TB] FAIL %s_flags%0d: done/busy got %b/%b expected %b/%b",
                         name, i, wDoneQ[i], wBusyQ[i], (i == n - 1), (i != n - 1));
            end
        end
        expWrap  = (n >= DEPTH);
        expStart = expWrap ? AW'(n % DEPTH) : '0;
        checkCount++;
        if (trig_addr !== AW'(trigIdx % DEPTH)) begin
            errCount++;
            $display("[TB] FAIL %s_trig_addr: got %0d expected %0d", name, trig_addr, trigIdx % DEPTH);
        end
        checkCount++;
        if (wrapped !== expWrap || start_addr !== expStart) begin
            errCount++;
            $display("[TB] FAIL %s_wrap: wrapped/start got %b/%0d expected %b/%0d",
                     name, wrapped, start_addr, expWrap, expStart);
        end
        checkCount++;
        if (done !== 1'b1 || busy !== 1'b0 || weA !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL %s_final: done/busy/weA got %b/%b/%b expected 1/0/0", name, done, busy, weA);
        end
        checkCount++;
        if (enErr != 0) begin
            errCount++;
            $display("[TB] FAIL %s_enA: enA differed from weA %0d times, expected 0", name, enErr);
            enErr = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid = 1'b1;
        trigger = 1'b1;
        arm = 1'b1;
        repeat (2) tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        arm = 1'b0;
        s_valid = 1'b0;
        trigger = 1'b0;
        tick();
        checkIdleOutputs("reset_release");
    endtask

    task automatic test_basic();
        run_capture(3, 5, 0, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_wrap();
        run_capture(4, 19, 0, 1'b0, 1'b0, "wrap");
        run_capture(15, 0, 0, 1'b0, 1'b0, "fullwrap");
        run_capture(0, 14, 0, 1'b0, 1'b0, "justbelow");
    endtask

    task automatic test_post_zero();
        run_capture(0, 0, 0, 1'b0, 1'b0, "postzero");
    endtask

    task automatic test_gaps();
        run_capture(5, 7, 2, 1'b1, 1'b0, "gaps");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            int mode;
            mode = int'($urandom_range(0, 3)) - 1;
            run_capture(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                        mode, 1'($urandom % 2), 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        clearLog();
        arm = 1'b1;
        post_count = 4'd5;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            trigger = (i == 2);
            tick();
        end
        rst = 1'b1;
        s_data = $urandom;
        trigger = 1'b0;
        tick();
        checkIdleOutputs("reset_mid");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            trigger = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        trigger = 1'b0;
        tick();
        checkCount++;
        if (wAddrQ.size() != 5 || busy !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_mid_after: writes/busy got %0d/%b expected 5/0", wAddrQ.size(), busy);
        end
    endtask

    task automatic test_arm_with_reset();
        clearLog();
        rst = 1'b1;
        arm = 1'b1;
        post_count = 4'd0;
        tick();
        rst = 1'b0;
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            trigger = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        trigger = 1'b0;
        tick();
        checkCount++;
        if (wAddrQ.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL arm_rst: writes/busy/done got %0d/%b/%b expected 0/0/0",
                     wAddrQ.size(), busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_post_zero();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_arm_with_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/capture_writer.md
# capture_writer

Write-side controller for the IBERT sample-capture memory. Accepts a stream of received/error samples on clkA, writes them into the block memory write port (weA/enA/addrA/dinA) as a circular buffer, and freezes capture a programmable number of samples after a trigger. Reports the trigger address and the oldest valid address so the clkB readout logic can unroll the buffer.

## Interface
Parameters:
- WIDTH, 32, sample width; equals memory WIDTH.
- DEPTH, 512, memory depth; power of two, ≥ 4.
- AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clkA  in  1  capture clock.
- rst  in  1  reset; synchronous, active-high; clock clkA.
- arm  in  1  one-cycle pulse; starts a capture.
- post_count  in  AW  samples written after the trigger sample (0..DEPTH-1); sampled on arm.
- s_data  in  WIDTH  sample.
- s_valid  in  1  sample qualifier; no backpressure.
- trigger  in  1  trigger, qualified by s_valid.
- weA  out  1  memory write enable.
- enA  out  1  memory port enable; equals weA.
- addrA  out  AW  memory write address.
- dinA  out  WIDTH  memory write data.
- busy  out  1  high in ARMED or POST.
- done  out  1  high in DONE.
- wrapped  out  1  buffer has wrapped at least once this capture.
- trig_addr  out  AW  address holding the trigger sample.
- start_addr  out  AW  oldest valid address: wrapped ? write pointer : 0.

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE/DONE: samples dropped. arm → ARMED; write pointer ← 0, wrapped ← 0, post counter ← post_count, trig_addr ← 0. done clears on arm.
- ARMED: every accepted sample written at pointer, pointer increments mod DEPTH. Pointer DEPTH-1 → 0 sets wrapped (sticky). Accepted sample with trigger=1: written, trig_addr ← its address; post_count==0 → DONE, else → POST.
- POST: each accepted sample written, counter decrements; the write that brings counter to 0 → DONE. trigger ignored.
- arm ignored in ARMED/POST. trigger without s_valid ignored in all states.
- post_count ≤ DEPTH-1 guarantees the trigger sample is never overwritten.

## Timing
- Write outputs registered: sample accepted in cycle N drives weA/enA/addrA/dinA in cycle N+1, for exactly one cycle per sample. Back-to-back samples give back-to-back writes.
- done rises in the cycle the final write is presented (same cycle as its weA).
- busy/done/wrapped/trig_addr update with the same one-cycle latency as the writes.
- Reset: state IDLE; weA, enA, busy, done, wrapped = 0; addrA, dinA, trig_addr, start_addr = 0. rst mid-capture aborts immediately; no further writes; memory contents untouched.
- Simultaneous arm and rst: rst wins. arm and s_valid in same cycle in IDLE: sample dropped, capture starts next cycle.

## Configuration
- CAPTURE_DECIM_EN defined: adds input decim [7:0] (sampled on arm); in ARMED/POST only every (decim+1)-th valid sample is accepted, counter reset on arm; a valid trigger on a non-accepted sample is held pending and applied to the next accepted sample.
- Undefined: no decim port; every valid sample accepted.

## Structure
- Package ibert_capture_pkg: state enum cap_state_t, function for AW from DEPTH, shared with clkB readout.
- Optional sub-module capture_decim (decimation counter + pending trigger), instantiated only under CAPTURE_DECIM_EN.

## Test plan
- DEPTH=16, arm, post_count=3, 5 samples then trigger on 6th (value 0x55) → writes addr 0..8, trig_addr=5, done with addrA=8, wrapped=0, start_addr=0.
- DEPTH=16, post_count=4, trigger on sample 20 → trig_addr=3, wrapped=1, last write addr 7, start_addr=8.
- post_count=0, trigger on first sample → single write addr 0, done same cycle as weA.
- s_valid gaps (1 of every 3 cycles) → weA pulses one-to-one with valid, no write while s_valid low; arm during POST ignored.
- rst asserted in POST after 2 post writes → next cycle weA=0, busy=0, done=0, all outputs zero.
- CAPTURE_DECIM_EN, decim=2, continuous valid → writes at samples 0,3,6,…; trigger on sample 4 applies to sample 6.
